// File: rtl/serial_sub_311_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_311_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_311_fs.sv
// One-bit full subtractor used once per SHIFT cycle.
module fs_311 (
  input  logic a_i,
  input  logic b_i,
  input  logic br_i,
  output logic diff_o,
  output logic br_o
);

  assign diff_o = a_i ^ b_i ^ br_i;
  assign br_o   = (~a_i & b_i) | (~a_i & br_i) | (b_i & br_i);

endmodule

// File: rtl/serial_sub_311.sv
// Bit-serial subtractor: computes a-b-bin LSB first over WIDTH cycles,
// reporting difference, final borrow and signed overflow.
module serial_sub_311
  import serial_sub_311_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_311,
  input  logic             rst_311,
  input  logic             start_311,
  input  logic [WIDTH-1:0] a_311,
  input  logic [WIDTH-1:0] b_311,
  input  logic             bin_311,
  output logic             busy_311,
  output logic             done_311,
  output logic [WIDTH-1:0] d_311,
  output logic             bout_311,
  output logic             ovf_311
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fs_diff_s;
  logic fs_br_s;

  fs_311 u_fs (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .br_i   (br_q),
    .diff_o (fs_diff_s),
    .br_o   (fs_br_s)
  );

  // State register and datapath registers
  always_ff @(posedge clk_311 or posedge rst_311) begin
    if (rst_311) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update; busy/done are precomputed so they register with the state
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_311) begin
          a_d     = a_311;
          b_d     = b_311;
          br_d    = bin_311;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = {fs_diff_s, res_q[WIDTH-1:1]};
        br_d  = fs_br_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // br_q is the borrow into the MSB, fs_br_s the borrow out of it
          bout_d  = fs_br_s;
          ovf_d   = br_q ^ fs_br_s;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign busy_311 = busy_q;
  assign done_311 = done_q;
  assign d_311    = res_q;
  assign bout_311 = bout_q;
  assign ovf_311  = ovf_q;

endmodule
